// File: rtl/load_fu_pkg.sv
// Shared load-unit types: issued-entry layout, FSM states, load funct3 codes
// and the branch-tag flush-hit test that the reservation stations also use.
package load_fu_pkg;

  localparam int ROB_IDX_W = 3;
  localparam int BR_TAG_W  = 4;

  typedef struct packed {
    logic                sign;
    logic [BR_TAG_W-1:0] tag;
  } branch_tag_t;

  typedef struct packed {
    logic [31:0]          rs1_data;
    logic [31:0]          imm;
    logic [2:0]           funct3;
    logic [ROB_IDX_W-1:0] rob_idx;
    branch_tag_t          br_tag;
  } ResEntryLd_reg_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, BCAST} ld_fu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // An entry is younger than the mispredicted branch when its tag covers the
  // branch's bits; the sign bit flips which side must cover the other.
  function automatic logic flush_hit(input branch_tag_t entry_tag,
                                     input branch_tag_t mispred_tag);
    if (entry_tag.sign == mispred_tag.sign)
      return (entry_tag.tag & mispred_tag.tag) == mispred_tag.tag;
    else
      return (entry_tag.tag & mispred_tag.tag) == entry_tag.tag;
  endfunction

endpackage

// File: rtl/load_fu_align.sv
// Byte-lane logic for loads: read mask for the request and the shifted,
// sign- or zero-extended value extracted from the returned word.
module load_align
  import load_fu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value,
  output logic [3:0]  rmask
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_LB:   value = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  value = {24'b0, shifted[7:0]};
      F3_LH:   value = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  value = {16'b0, shifted[15:0]};
      default: value = shifted;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_LB, F3_LBU: rmask = 4'b0001 << offset;
      F3_LH, F3_LHU: rmask = 4'b0011 << offset;
      default:       rmask = 4'b1111;
    endcase
  end

endmodule

// File: rtl/load_fu.sv
// Load functional unit: address generation, one data-memory read, CDB broadcast.
// Optional macro LD_MISALIGN_TRAP_EN reports misaligned LH/LW as an exception on cdb_exc.
module load_fu
  import load_fu_pkg::*;
#(
  parameter int          ROB_WIDTH   = ROB_IDX_W,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  branch_tag_t          flush_tag,
  input  logic                 issue,
  input  ResEntryLd_reg_t      entry_in,
  output logic                 fu_running,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp,
  output logic                 cdb_req,
  input  logic                 cdb_grant,
  output logic [ROB_WIDTH-1:0] cdb_rob,
`ifdef LD_MISALIGN_TRAP_EN
  output logic                 cdb_exc,
`endif
  output logic [31:0]          cdb_value
);

  ld_fu_state_t         state;
  logic                 squashed;
  logic [1:0]           off_q;
  logic [2:0]           funct3_q;
  logic [ROB_IDX_W-1:0] rob_q;
  branch_tag_t          br_q;

  logic [31:0] eff_addr;
  logic        issue_hit;
  logic        entry_hit;
  logic [1:0]  align_off;
  logic [2:0]  align_f3;
  logic [31:0] align_value;
  logic [3:0]  align_rmask;

  assign eff_addr   = entry_in.rs1_data + entry_in.imm;
  assign issue_hit  = flush && flush_hit(entry_in.br_tag, flush_tag);
  assign entry_hit  = flush && flush_hit(br_q, flush_tag);
  assign fu_running = (state != IDLE);

  // The aligner serves the incoming entry's mask in IDLE and the latched entry's data later.
  assign align_off = (state == IDLE) ? eff_addr[1:0]   : off_q;
  assign align_f3  = (state == IDLE) ? entry_in.funct3 : funct3_q;

  load_align u_align (
    .rdata  (dmem_rdata),
    .offset (align_off),
    .funct3 (align_f3),
    .value  (align_value),
    .rmask  (align_rmask)
  );

`ifdef LD_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (((entry_in.funct3 == F3_LH) || (entry_in.funct3 == F3_LHU)) && eff_addr[0])
                   || ((entry_in.funct3 == F3_LW) && (eff_addr[1:0] != 2'b00));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      squashed   <= 1'b0;
      off_q      <= '0;
      funct3_q   <= '0;
      rob_q      <= '0;
      br_q       <= '0;
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      cdb_req    <= 1'b0;
      cdb_rob    <= '0;
      cdb_value  <= '0;
`ifdef LD_MISALIGN_TRAP_EN
      cdb_exc    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (issue && !issue_hit) begin
            off_q    <= eff_addr[1:0];
            funct3_q <= entry_in.funct3;
            rob_q    <= entry_in.rob_idx;
            br_q     <= entry_in.br_tag;
            squashed <= 1'b0;
`ifdef LD_MISALIGN_TRAP_EN
            if (misaligned) begin
              cdb_req   <= 1'b1;
              cdb_value <= eff_addr;
              cdb_rob   <= ROB_WIDTH'(entry_in.rob_idx);
              cdb_exc   <= 1'b1;
              state     <= BCAST;
            end else
`endif
            begin
              dmem_addr  <= {eff_addr[31:2], 2'b00};
              dmem_rmask <= align_rmask;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          dmem_rmask <= '0;
          if (entry_hit) squashed <= 1'b1;
          state <= WAIT;
        end
        // The request cannot be withdrawn, so a squashed load still waits for its data.
        WAIT: begin
          if (dmem_resp) begin
            if (squashed || entry_hit) begin
              state <= IDLE;
            end else begin
              cdb_req   <= 1'b1;
              cdb_value <= align_value;
              cdb_rob   <= ROB_WIDTH'(rob_q);
`ifdef LD_MISALIGN_TRAP_EN
              cdb_exc   <= 1'b0;
`endif
              state     <= BCAST;
            end
          end else if (entry_hit) begin
            squashed <= 1'b1;
          end
        end
        BCAST: begin
          if (cdb_grant || entry_hit) begin
            cdb_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(issue && fu_running));

  generate
    if (MEM_TIMEOUT != 0) begin : g_watchdog
      logic [31:0] wait_cycles;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                wait_cycles <= '0;
        else if (state == WAIT) wait_cycles <= wait_cycles + 32'd1;
        else                    wait_cycles <= '0;
      end
      assert property (@(posedge clk) disable iff (rst) wait_cycles < MEM_TIMEOUT);
    end
  endgenerate

endmodule
